mem_march_tester: RTL

- Initiator-side engine that drives the single-port RAM's read/wr/address/data_write strobes and checks its `out` bus.
- Runs a two-phase write-then-readback pattern test over addresses 0..DEPTH-1.
- Reports pass, or the first failing address, observed data and phase.
- Sits between system control (start/done) and the RAM instance, replacing hand-written stimulus sequences.

---
 rtl/mem_march_tester.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_march_tester.sv
// rtl/mem_march_tester.sv - two-phase write/readback march tester for a single-port RAM
module mem_march_tester #(
  parameter int ADD_WIDTH = 6,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] SEED = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADD_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  fail_phase,
  output logic                  mem_wr,
  output logic                  mem_read,
  output logic [ADD_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_write,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [ADD_WIDTH-1:0] LAST = ADD_WIDTH'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic [ADD_WIDTH-1:0]    addr, addr_nxt;
  logic                    phase, phase_nxt;
  logic                    pass_nxt, fail_phase_nxt;
  logic [ADD_WIDTH-1:0]    fail_addr_nxt;
  logic [DATA_WIDTH-1:0]   fail_data_nxt;
  logic [DATA_WIDTH-1:0]   base_cur, base_nxt;
  logic [DATA_WIDTH-1:0]   pat_cur, pat_nxt;

  // Pattern base is the low data-width bits of the address, zero-extended when narrower.
  generate
    if (ADD_WIDTH >= DATA_WIDTH) begin : g_trunc
      assign base_cur = addr[DATA_WIDTH-1:0];
      assign base_nxt = addr_nxt[DATA_WIDTH-1:0];
    end else begin : g_zext
      assign base_cur = DATA_WIDTH'(addr);
      assign base_nxt = DATA_WIDTH'(addr_nxt);
    end
  endgenerate

  assign pat_cur = phase ? ~(base_cur ^ SEED) : (base_cur ^ SEED);
  assign pat_nxt = phase_nxt ? ~(base_nxt ^ SEED) : (base_nxt ^ SEED);

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    phase_nxt      = phase;
    pass_nxt       = pass;
    fail_addr_nxt  = fail_addr;
    fail_data_nxt  = fail_data;
    fail_phase_nxt = fail_phase;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = WRITE;
          addr_nxt       = '0;
          phase_nxt      = 1'b0;
          pass_nxt       = 1'b0;
          fail_addr_nxt  = '0;
          fail_data_nxt  = '0;
          fail_phase_nxt = 1'b0;
        end
      end
      WRITE: begin
        if (addr == LAST) begin
          addr_nxt  = '0;
          state_nxt = READ;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      READ: state_nxt = CHECK;
      CHECK: begin
        // mem_out carries the word requested in the preceding READ cycle.
        if (mem_out != pat_cur) begin
          fail_addr_nxt  = addr;
          fail_data_nxt  = mem_out;
          fail_phase_nxt = phase;
          pass_nxt       = 1'b0;
          state_nxt      = DONE;
        end else if (addr == LAST) begin
          if (!phase) begin
            phase_nxt = 1'b1;
            addr_nxt  = '0;
            state_nxt = WRITE;
          end else begin
            pass_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          addr_nxt  = addr + 1'b1;
          state_nxt = READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      phase          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_addr      <= '0;
      fail_data      <= '0;
      fail_phase     <= 1'b0;
      mem_wr         <= 1'b0;
      mem_read       <= 1'b0;
      mem_address    <= '0;
      mem_data_write <= '0;
    end else begin
      state          <= state_nxt;
      addr           <= addr_nxt;
      phase          <= phase_nxt;
      pass           <= pass_nxt;
      fail_addr      <= fail_addr_nxt;
      fail_data      <= fail_data_nxt;
      fail_phase     <= fail_phase_nxt;
      busy           <= (state_nxt == WRITE) || (state_nxt == READ) || (state_nxt == CHECK);
      done           <= (state_nxt == DONE);
      mem_wr         <= (state_nxt == WRITE);
      mem_read       <= (state_nxt == READ);
      mem_address    <= addr_nxt;
      mem_data_write <= (state_nxt == WRITE) ? pat_nxt : '0;
    end
  end

endmodule
